user_switch_bank: RTL and testbench

USER_SWITCH_BANK -- requirements
Module: user_switch_bank

---
 rtl/user_switch_bank.sv | 102 ++++++++++
 tb/tb_user_switch_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/user_switch_bank.sv
// Multi-channel switch debouncer.
// Each raw level is optionally inverted, passed through a two-flop synchroniser
// and committed only after it has differed from the debounced state for
// DEBOUNCE_CYCLES consecutive cycles. Commits produce one-cycle edge pulses and
// set a sticky per-channel event flag.
module user_switch_bank #(
  parameter int unsigned                   NUM_CHANNELS    = 4,
  parameter int unsigned                   DEBOUNCE_CYCLES = 1000000,
  parameter logic        [NUM_CHANNELS-1:0] INVERT_MASK    = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] raw_switch,
  input  logic [NUM_CHANNELS-1:0] clear_events,
  output logic [NUM_CHANNELS-1:0] switch_state,
  output logic [NUM_CHANNELS-1:0] rise_pulse,
  output logic [NUM_CHANNELS-1:0] fall_pulse,
  output logic [NUM_CHANNELS-1:0] event_pending,
  output logic                    any_event
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int unsigned    CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CHANNELS-1:0]           logic_in;
  logic [NUM_CHANNELS-1:0]           sync1_q, sync2_q;
  logic [NUM_CHANNELS-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NUM_CHANNELS-1:0]           state_q, state_d;
  logic [NUM_CHANNELS-1:0]           rise_q, rise_d;
  logic [NUM_CHANNELS-1:0]           fall_q, fall_d;
  logic [NUM_CHANNELS-1:0]           pend_q, pend_d;
  logic [NUM_CHANNELS-1:0]           commit;

  // Polarity correction happens before synchronisation so both flops see the logical level.
  assign logic_in = raw_switch ^ INVERT_MASK;

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= logic_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce counter, commit decision, pulses and sticky flags.
  always_comb begin
    commit  = '0;
    cnt_d   = cnt_q;
    state_d = state_q;
    rise_d  = '0;
    fall_d  = '0;
    pend_d  = pend_q;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      if (sync2_q[i] == state_q[i]) begin
        // Input returned to the committed level: any pending change is cancelled.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        commit[i]  = 1'b1;
        cnt_d[i]   = '0;
        state_d[i] = sync2_q[i];
        rise_d[i]  = sync2_q[i];
        fall_d[i]  = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      // A commit wins over a simultaneous clear so no event is ever lost.
      if (commit[i]) begin
        pend_d[i] = 1'b1;
      end else if (clear_events[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
    end
  end

  assign switch_state  = state_q;
  assign rise_pulse    = rise_q;
  assign fall_pulse    = fall_q;
  assign event_pending = pend_q;
  assign any_event     = |pend_q;

endmodule

// File: tb/tb_user_switch_bank.sv
// Directed bench for user_switch_bank: a per-cycle vector table for the main
// debounce behaviour plus hand-written reset-mid-count and DEBOUNCE_CYCLES=1 cases.
module tb_user_switch_bank;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] raw, clr;
  logic [3:0] st, ri, fa, pe;
  logic       any;

  logic [3:0] raw_inv = 4'b0000;
  logic [3:0] st_i, ri_i, fa_i, pe_i;
  logic       any_i;

  logic       raw_d1 = 1'b0;
  logic       st_d1, ri_d1, fa_d1, pe_d1, any_d1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  user_switch_bank #(
    .NUM_CHANNELS   (4),
    .DEBOUNCE_CYCLES(4),
    .INVERT_MASK    (4'b0000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .raw_switch   (raw),
    .clear_events (clr),
    .switch_state (st),
    .rise_pulse   (ri),
    .fall_pulse   (fa),
    .event_pending(pe),
    .any_event    (any)
  );

  user_switch_bank #(
    .NUM_CHANNELS   (4),
    .DEBOUNCE_CYCLES(4),
    .INVERT_MASK    (4'b1000)
  ) dut_inv (
    .clock        (clock),
    .reset        (reset),
    .raw_switch   (raw_inv),
    .clear_events (4'b0000),
    .switch_state (st_i),
    .rise_pulse   (ri_i),
    .fall_pulse   (fa_i),
    .event_pending(pe_i),
    .any_event    (any_i)
  );

  user_switch_bank #(
    .NUM_CHANNELS   (1),
    .DEBOUNCE_CYCLES(1),
    .INVERT_MASK    (1'b0)
  ) dut_d1 (
    .clock        (clock),
    .reset        (reset),
    .raw_switch   (raw_d1),
    .clear_events (1'b0),
    .switch_state (st_d1),
    .rise_pulse   (ri_d1),
    .fall_pulse   (fa_d1),
    .event_pending(pe_d1),
    .any_event    (any_d1)
  );

  typedef struct packed {
    logic [3:0] raw;
    logic [3:0] clr;
    logic [3:0] st;
    logic [3:0] ri;
    logic [3:0] fa;
    logic [3:0] pe;
    logic [3:0] ist;
    logic [3:0] iri;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state"}, st, 4'b0000);
    check({tag, " rise"},  ri, 4'b0000);
    check({tag, " fall"},  fa, 4'b0000);
    check({tag, " pend"},  pe, 4'b0000);
    check({tag, " any"},   {3'b000, any}, 4'b0000);
  endtask

  initial begin
    // Row k: inputs applied before edge k (counted from reset release), outputs after it.
    //            raw      clr      st       ri       fa       pe       ist      iri
    tbl[0]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b1000, 4'b1000};
    tbl[6]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0000};
    tbl[7]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    tbl[8]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    tbl[9]  = '{4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    tbl[10] = '{4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    tbl[11] = '{4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    tbl[12] = '{4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    tbl[13] = '{4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    tbl[14] = '{4'b0101, 4'b0000, 4'b0101, 4'b0100, 4'b0000, 4'b0100, 4'b1000, 4'b0000};
    tbl[15] = '{4'b0001, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000};
    tbl[16] = '{4'b0001, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000};
    tbl[17] = '{4'b0001, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000};
    tbl[18] = '{4'b0001, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000};
    tbl[19] = '{4'b0001, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000};
    tbl[20] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b1000, 4'b0000};
    tbl[21] = '{4'b0001, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};

    // Reset state.
    reset = 1'b1;
    raw   = 4'b0000;
    clr   = 4'b0000;
    step();
    step();
    check_all_zero("reset");
    check("reset inv state", st_i, 4'b0000);
    reset = 1'b0;

    // Main table.
    for (int k = 0; k < 22; k++) begin
      raw = tbl[k].raw;
      clr = tbl[k].clr;
      step();
      check($sformatf("row%0d state", k + 1), st, tbl[k].st);
      check($sformatf("row%0d rise", k + 1), ri, tbl[k].ri);
      check($sformatf("row%0d fall", k + 1), fa, tbl[k].fa);
      check($sformatf("row%0d pend", k + 1), pe, tbl[k].pe);
      check($sformatf("row%0d any", k + 1), {3'b000, any}, {3'b000, |tbl[k].pe});
      check($sformatf("row%0d inv state", k + 1), st_i, tbl[k].ist);
      check($sformatf("row%0d inv rise", k + 1), ri_i, tbl[k].iri);
      check($sformatf("row%0d inv fall", k + 1), fa_i, 4'b0000);
    end
    clr = 4'b0000;

    // Reset mid-count on channel 3: the pending change must restart from zero.
    #1 reset = 1'b1;
    #1 check_all_zero("rst1 async");
    raw = 4'b1000;
    step();
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("precount e%0d state", e), st, 4'b0000);
    end
    #1 reset = 1'b1;
    #1 check_all_zero("rst2 async");
    step();
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      check($sformatf("restart e%0d state", e), st, (e == 6) ? 4'b1000 : 4'b0000);
      check($sformatf("restart e%0d rise", e), ri, (e == 6) ? 4'b1000 : 4'b0000);
    end
    step();
    check("restart after rise", ri, 4'b0000);
    check("restart hold state", st, 4'b1000);
    check("restart pend", pe, 4'b1000);

    // DEBOUNCE_CYCLES=1 commits on the first cycle sync2 differs.
    raw_d1 = 1'b1;
    step();
    step();
    check("d1 e2 state", {3'b000, st_d1}, 4'b0000);
    step();
    check("d1 e3 state", {3'b000, st_d1}, 4'b0001);
    check("d1 e3 rise", {3'b000, ri_d1}, 4'b0001);
    step();
    check("d1 e4 rise", {3'b000, ri_d1}, 4'b0000);
    check("d1 e4 pend", {3'b000, pe_d1}, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
